// File: rtl/fetch_unit_rv.sv
// Multicycle instruction-fetch unit: owns the PC, fetches from a variable-latency
// instruction memory into an instruction register, and hands it off via valid/ready.
module fetch_unit_rv #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ILEN-1:0]   imem_rdata,
  input  logic              imem_ready,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ILEN-1:0]   instr,
  output logic [XLEN-1:0]   instr_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fetch_fault,
  output logic [1:0]        fault_cause,
  output logic [XLEN-1:0]   fault_pc,
  output logic [XLEN-1:0]   fetch_count
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam int unsigned       WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [XLEN-1:0]   STEP      = XLEN'(PC_STEP);

  logic [1:0]        state;
  logic [XLEN-1:0]   pc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              redirect_aligned;
  logic              timeout_hit;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign timeout_hit      = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc[ADDR_W-1:0];
  assign instr_valid = (state == S_HOLD);
  assign fetch_fault = (state == S_FAULT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      fault_cause <= '0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // Redirect wins in every state; fault regs are already clear outside FAULT,
      // so an aligned redirect clears them unconditionally.
      wait_cnt <= '0;
      if (redirect_aligned) begin
        pc          <= redirect_pc;
        state       <= S_REQ;
        fault_cause <= '0;
        fault_pc    <= '0;
      end else begin
        state       <= S_FAULT;
        fault_cause <= CAUSE_MISALIGN;
        fault_pc    <= redirect_pc;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            pc       <= pc + STEP;
            wait_cnt <= '0;
            state    <= S_HOLD;
          end else if (timeout_hit) begin
            wait_cnt    <= '0;
            state       <= S_FAULT;
            fault_cause <= CAUSE_TIMEOUT;
            fault_pc    <= pc;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            fetch_count <= fetch_count + 1'b1;
            state       <= S_REQ;
          end
        end
        S_FAULT: ;
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit_rv.sv
// Bench for fetch_unit_rv: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit_rv;

  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [63:0] fault_pc;
  logic [63:0] fetch_count;

  fetch_unit_rv #(
    .XLEN(64), .ILEN(32), .ADDR_W(32), .RESET_PC(64'h0), .PC_STEP(4), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        fault;
    logic [1:0]  cause;
    logic [63:0] fpc;
    logic [63:0] count;
  } outs_t;

  typedef struct {
    logic        redir;
    logic [63:0] rpc;
    logic        ready;
    logic [31:0] rdata;
    logic        iready;
    outs_t       e;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic cmp(input string tag, input string fld, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s %s: got %h want %h", tag, fld, got, want);
    end
  endtask

  task automatic check(input string tag, input outs_t e);
    cmp(tag, "imem_req",    64'(imem_req),    64'(e.req));
    cmp(tag, "imem_addr",   64'(imem_addr),   64'(e.addr));
    cmp(tag, "instr_valid", 64'(instr_valid), 64'(e.valid));
    cmp(tag, "instr",       64'(instr),       64'(e.instr));
    cmp(tag, "instr_pc",    instr_pc,         e.ipc);
    cmp(tag, "fetch_fault", 64'(fetch_fault), 64'(e.fault));
    cmp(tag, "fault_cause", 64'(fault_cause), 64'(e.cause));
    cmp(tag, "fault_pc",    fault_pc,         e.fpc);
    cmp(tag, "fetch_count", fetch_count,      e.count);
  endtask

  function automatic outs_t mko(input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] ins, input logic [63:0] ipc, input logic fault,
                                input logic [1:0] cause, input logic [63:0] fpc, input logic [63:0] count);
    outs_t o;
    o.req = req; o.addr = addr; o.valid = valid; o.instr = ins; o.ipc = ipc;
    o.fault = fault; o.cause = cause; o.fpc = fpc; o.count = count;
    return o;
  endfunction

  function automatic vec_t mk(input logic redir, input logic [63:0] rpc, input logic ready,
                              input logic [31:0] rdata, input logic iready, input outs_t e);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ready = ready; v.rdata = rdata; v.iready = iready; v.e = e;
    return v;
  endfunction

  task automatic drive(input logic redir, input logic [63:0] rpc, input logic ready,
                       input logic [31:0] rdata, input logic iready);
    redirect_valid = redir; redirect_pc = rpc; imem_ready = ready;
    imem_rdata = rdata; instr_ready = iready;
  endtask

  // Reference model: one fetch transaction at a time, described by what has happened
  logic [63:0] m_pc, m_ipc, m_fpc, m_count;
  logic [31:0] m_instr;
  logic [1:0]  m_cause;
  bit          m_holding, m_faulted;
  int unsigned m_waited;

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_fpc = 0; m_count = 0; m_instr = 0; m_cause = 0;
    m_holding = 0; m_faulted = 0; m_waited = 0;
  endtask

  task automatic model_step(input logic redir, input logic [63:0] rpc, input logic ready,
                            input logic [31:0] rdata, input logic iready);
    if (redir) begin
      m_waited  = 0;
      m_holding = 0;
      if (rpc % 4 == 0) begin
        m_pc = rpc; m_faulted = 0; m_cause = 0; m_fpc = 0;
      end else begin
        m_faulted = 1; m_cause = 2'b01; m_fpc = rpc;
      end
    end else if (m_faulted) begin
    end else if (m_holding) begin
      if (iready) begin
        m_count   = m_count + 1;
        m_holding = 0;
      end
    end else if (ready) begin
      m_instr = rdata; m_ipc = m_pc; m_pc = m_pc + 4; m_holding = 1; m_waited = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        m_faulted = 1; m_cause = 2'b10; m_fpc = m_pc; m_waited = 0;
      end
    end
  endtask

  function automatic outs_t model_outs();
    return mko(!m_faulted && !m_holding, m_pc[31:0], m_holding && !m_faulted, m_instr, m_ipc,
               m_faulted, m_cause, m_fpc, m_count);
  endfunction

  vec_t  tbl[22];
  outs_t e;

  initial begin
    // Directed table: each row's expectation is the state after that row's clock edge
    tbl[0]  = mk(0, 0, 1, 32'h0000_0013, 1, mko(0, 32'h4, 1, 32'h13, 0, 0, 0, 0, 0));
    tbl[1]  = mk(0, 0, 1, 32'hDEAD_BEEF, 1, mko(1, 32'h4, 0, 32'h13, 0, 0, 0, 0, 1));
    tbl[2]  = mk(0, 0, 1, 32'h1111_1111, 0, mko(0, 32'h8, 1, 32'h1111_1111, 64'h4, 0, 0, 0, 1));
    tbl[3]  = mk(0, 0, 0, 32'h0,         1, mko(1, 32'h8, 0, 32'h1111_1111, 64'h4, 0, 0, 0, 2));
    for (int i = 4; i <= 6; i++)
      tbl[i] = mk(0, 0, 0, 32'h0, 0, mko(1, 32'h8, 0, 32'h1111_1111, 64'h4, 0, 0, 0, 2));
    tbl[7]  = mk(0, 0, 1, 32'h00A0_0093, 0, mko(0, 32'hC, 1, 32'h00A0_0093, 64'h8, 0, 0, 0, 2));
    for (int i = 8; i <= 12; i++)
      tbl[i] = mk(0, 0, 1, 32'hFFFF_FFFF, 0, mko(0, 32'hC, 1, 32'h00A0_0093, 64'h8, 0, 0, 0, 2));
    tbl[13] = mk(0, 0, 0, 32'h0, 1, mko(1, 32'hC, 0, 32'h00A0_0093, 64'h8, 0, 0, 0, 3));
    tbl[14] = mk(1, 64'h100, 1, 32'h0BAD, 1, mko(1, 32'h100, 0, 32'h00A0_0093, 64'h8, 0, 0, 0, 3));
    tbl[15] = mk(1, 64'h102, 0, 32'h0, 0, mko(0, 32'h100, 0, 32'h00A0_0093, 64'h8, 1, 2'b01, 64'h102, 3));
    tbl[16] = mk(0, 64'h0, 1, 32'h55, 1, mko(0, 32'h100, 0, 32'h00A0_0093, 64'h8, 1, 2'b01, 64'h102, 3));
    tbl[17] = mk(1, 64'h203, 1, 32'h0, 1, mko(0, 32'h100, 0, 32'h00A0_0093, 64'h8, 1, 2'b01, 64'h203, 3));
    tbl[18] = mk(1, 64'h200, 0, 32'h0, 0, mko(1, 32'h200, 0, 32'h00A0_0093, 64'h8, 0, 0, 0, 3));
    tbl[19] = mk(0, 64'h0, 1, 32'h22, 0, mko(0, 32'h204, 1, 32'h22, 64'h200, 0, 0, 0, 3));
    tbl[20] = mk(1, 64'h300, 0, 32'h0, 1, mko(1, 32'h300, 0, 32'h22, 64'h200, 0, 0, 0, 3));
    tbl[21] = mk(1, 64'h40, 0, 32'h0, 0, mko(1, 32'h40, 0, 32'h22, 64'h200, 0, 0, 0, 3));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    check("reset", mko(1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].redir, tbl[i].rpc, tbl[i].ready, tbl[i].rdata, tbl[i].iready);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("row%0d", i), tbl[i].e);
    end

    // Timeout: 16 waiting cycles after REQ entry at pc=0x40
    e = tbl[21].e;
    for (int k = 1; k <= int'(TO); k++) begin
      drive(0, 0, 0, 32'h0, 0);
      @(posedge clock);
      @(negedge clock);
      if (k == int'(TO)) begin
        e.req = 0; e.fault = 1; e.cause = 2'b10; e.fpc = 64'h40;
      end
      check($sformatf("timeout%0d", k), e);
    end

    // Asynchronous reset in the middle of FAULT, away from any clock edge
    #2 reset = 1'b1;
    #1 check("async_reset", mko(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b0;

    // PC wrap at the top of the address space
    drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 0);
    @(posedge clock); @(negedge clock);
    check("wrap_redir", mko(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 1, 32'h77, 0);
    @(posedge clock); @(negedge clock);
    check("wrap_fetch", mko(0, 32'h0, 1, 32'h77, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0));
    drive(0, 0, 0, 32'h0, 1);
    @(posedge clock); @(negedge clock);
    check("wrap_consume", mko(1, 32'h0, 0, 32'h77, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1));

    // Randomized traffic against the reference model
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r_redir, r_ready, r_iready;
      logic [63:0] r_rpc;
      logic [31:0] r_rdata;
      int unsigned ready_pct;
      case ((cyc / 250) % 3)
        0:       ready_pct = 70;
        1:       ready_pct = 4;
        default: ready_pct = 40;
      endcase
      r_redir  = ($urandom_range(0, 99) < 8);
      r_ready  = ($urandom_range(0, 99) < ready_pct);
      r_iready = ($urandom_range(0, 99) < 60);
      r_rdata  = $urandom;
      case ($urandom_range(0, 2))
        0:       r_rpc = 64'($urandom_range(0, 4095));
        1:       r_rpc = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
        default: r_rpc = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 99) < 70) r_rpc = r_rpc & ~64'h3;
      drive(r_redir, r_rpc, r_ready, r_rdata, r_iready);
      model_step(r_redir, r_rpc, r_ready, r_rdata, r_iready);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("rand%0d", cyc), model_outs());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
